// File: rtl/amiga_reset_ctl.sv
// amiga_reset_ctl: A1000 reset controller.
// Drives the open-drain _RST/_HLT enables from power-on timing and, when
// AMIGA_RESET_KBD_RESET_EN is defined, from the keyboard "three-finger"
// reset (KCLK held low). With the macro undefined, only the power-on path
// exists and KCLK is ignored. It also flags a 68000 RESET instruction seen
// on the _RST net without touching the FSM.
//
// Handshake: none. All inputs are level signals; kbd_rst_req is a
// single-cycle strobe and carries no ready/acknowledge.
module amiga_reset_ctl #(
  parameter int unsigned CNT_W           = 24,
  parameter int unsigned POR_CYCLES      = 715909,
  parameter int unsigned KBD_LOW_CYCLES  = 715909,
  parameter int unsigned RST_HOLD_CYCLES = 1431818
) (
  input  logic       clk,
  input  logic       res_n,
  input  logic       kclk,
  input  logic       rst_in_n,
  output logic       rst_oe,
  output logic       hlt_oe,
  output logic       reset_active,
  output logic       kbd_rst_req,
  output logic       ext_rst,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    ST_POR     = 3'd0,
    ST_RUN     = 3'd1,
    ST_KBD_LOW = 3'd2,
    ST_KBD_RST = 3'd3,
    ST_HOLD    = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] POR_LAST = CNT_W'(POR_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             assert_q, assert_d;
  logic             req_q, req_d;
  logic             ext_q, ext_d;
  logic [1:0]       guard_q, guard_d;
  logic             rst_meta, rst_s;

  // Two-stage synchroniser for the sensed _RST net.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      rst_meta <= 1'b1;
      rst_s    <= 1'b1;
    end else begin
      rst_meta <= rst_in_n;
      rst_s    <= rst_meta;
    end
  end

`ifdef AMIGA_RESET_KBD_RESET_EN
  localparam logic [CNT_W-1:0] KBD_LAST  = CNT_W'(KBD_LOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD_CYCLES - 1);

  logic kclk_meta, kclk_s;

  // Two-stage synchroniser for the keyboard clock line.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      kclk_meta <= 1'b1;
      kclk_s    <= 1'b1;
    end else begin
      kclk_meta <= kclk;
      kclk_s    <= kclk_meta;
    end
  end
`else
  // Keyboard path absent: KCLK and the keyboard timing parameters are unused.
  logic unused_kbd;
  assign unused_kbd = ^{kclk, KBD_LOW_CYCLES == 0, RST_HOLD_CYCLES == 0};
`endif

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q  <= ST_POR;
      cnt_q    <= '0;
      assert_q <= 1'b1;
      req_q    <= 1'b0;
      ext_q    <= 1'b0;
      guard_q  <= 2'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      assert_q <= assert_d;
      req_q    <= req_d;
      ext_q    <= ext_d;
      guard_q  <= guard_d;
    end
  end

  // Next-state and counter logic; undecoded encodings fall back to POR.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = 1'b0;
    case (state_q)
      ST_POR: begin
        // KCLK is deliberately not looked at here: POR always completes.
        if (cnt_q == POR_LAST) begin
          cnt_d   = '0;
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_RUN: begin
`ifdef AMIGA_RESET_KBD_RESET_EN
        if (!kclk_s) begin
          state_d = ST_KBD_LOW;
          cnt_d   = CNT_ONE;
        end
`endif
      end
`ifdef AMIGA_RESET_KBD_RESET_EN
      ST_KBD_LOW: begin
        // A KCLK release beats a coincident terminal count.
        if (kclk_s) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else if (cnt_q == KBD_LAST) begin
          state_d = ST_KBD_RST;
          req_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_KBD_RST: begin
        if (kclk_s) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end
      end
      ST_HOLD: begin
        // Any new KCLK low restarts the hold interval.
        if (!kclk_s) begin
          cnt_d = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
`endif
      default: begin
        state_d = ST_POR;
        cnt_d   = '0;
      end
    endcase
  end

  // Reset enables follow the next state so they switch with the transition.
  always_comb begin
    assert_d = (state_d == ST_POR) || (state_d == ST_KBD_RST) || (state_d == ST_HOLD);
  end

  // External reset sense, blanked for two cycles after our own release
  // while the synchronised _RST net catches up.
  always_comb begin
    ext_d = !rst_s && !assert_q && (guard_q == 2'd0);
    if (assert_q && !assert_d) begin
      guard_d = 2'd2;
    end else if (guard_q != 2'd0) begin
      guard_d = guard_q - 2'd1;
    end else begin
      guard_d = 2'd0;
    end
  end

  assign rst_oe       = assert_q;
  assign hlt_oe       = assert_q;
  assign reset_active = assert_q;
  assign kbd_rst_req  = req_q;
  assign ext_rst      = ext_q;
  assign state        = state_q;

endmodule

// File: tb/tb_amiga_reset_ctl.sv
// Self-checking bench for amiga_reset_ctl with short timing parameters.
// A cycle model pushes expected outputs before each clock edge; the values
// are popped and compared on the following falling edge.
module tb_amiga_reset_ctl;

  localparam int POR_C  = 16;
  localparam int KBD_C  = 32;
  localparam int HOLD_C = 8;

  logic       clk;
  logic       res_n;
  logic       kclk;
  logic       cpu_rst;
  logic       rst_in_n;
  logic       rst_oe;
  logic       hlt_oe;
  logic       reset_active;
  logic       kbd_rst_req;
  logic       ext_rst;
  logic [2:0] state;

  // Wired-OR _RST net: low when this block or the CPU pulls it.
  assign rst_in_n = ~(rst_oe | cpu_rst);

  amiga_reset_ctl #(
    .CNT_W          (24),
    .POR_CYCLES     (POR_C),
    .KBD_LOW_CYCLES (KBD_C),
    .RST_HOLD_CYCLES(HOLD_C)
  ) dut (
    .clk         (clk),
    .res_n       (res_n),
    .kclk        (kclk),
    .rst_in_n    (rst_in_n),
    .rst_oe      (rst_oe),
    .hlt_oe      (hlt_oe),
    .reset_active(reset_active),
    .kbd_rst_req (kbd_rst_req),
    .ext_rst     (ext_rst),
    .state       (state)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, got running, exp finished");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Reference model of the controller.
  typedef struct {
    int   st;
    int   cnt;
    logic asrt;
    logic req;
    logic ext;
    int   guard;
    logic kmeta;
    logic ks;
    logic rmeta;
    logic rs;
  } mdl_t;

  mdl_t m;
  logic [7:0] exp_q[$];

  function automatic mdl_t model_reset();
    mdl_t r;
    r.st = 0; r.cnt = 0; r.asrt = 1'b1; r.req = 1'b0; r.ext = 1'b0;
    r.guard = 0; r.kmeta = 1'b1; r.ks = 1'b1; r.rmeta = 1'b1; r.rs = 1'b1;
    return r;
  endfunction

  function automatic mdl_t model_next(mdl_t c, logic k, logic cpu);
    mdl_t n;
    n = c;
    n.kmeta = k;
    n.ks    = c.kmeta;
    n.rmeta = !(c.asrt || cpu);
    n.rs    = c.rmeta;
    n.req   = 1'b0;
    case (c.st)
      0: begin
        if (c.cnt == POR_C - 1) begin n.st = 1; n.cnt = 0; end
        else n.cnt = c.cnt + 1;
      end
      1: begin
`ifdef AMIGA_RESET_KBD_RESET_EN
        if (!c.ks) begin n.st = 2; n.cnt = 1; end
`endif
      end
      2: begin
        if (c.ks) begin n.st = 1; n.cnt = 0; end
        else if (c.cnt == KBD_C - 1) begin n.st = 3; n.req = 1'b1; n.cnt = 0; end
        else n.cnt = c.cnt + 1;
      end
      3: begin
        if (c.ks) begin n.st = 4; n.cnt = 0; end
      end
      4: begin
        if (!c.ks) n.cnt = 0;
        else if (c.cnt == HOLD_C - 1) begin n.st = 1; n.cnt = 0; end
        else n.cnt = c.cnt + 1;
      end
      default: begin n.st = 0; n.cnt = 0; end
    endcase
    n.asrt = (n.st == 0) || (n.st == 3) || (n.st == 4);
    n.ext  = !c.rs && !c.asrt && (c.guard == 0);
    if (c.asrt && !n.asrt) n.guard = 2;
    else if (c.guard > 0) n.guard = c.guard - 1;
    return n;
  endfunction

  function automatic logic [7:0] pack_exp(mdl_t c);
    return {3'(c.st), c.asrt, c.asrt, c.asrt, c.req, c.ext};
  endfunction

  function automatic logic [7:0] pack_dut();
    return {state, rst_oe, hlt_oe, reset_active, kbd_rst_req, ext_rst};
  endfunction

  // Scoreboard comparison.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Driver: one clock, model advanced before the edge, DUT checked after.
  string phase = "init";
  int    req_seen = 0;

  task automatic step();
    logic [7:0] e;
    m = model_next(m, kclk, cpu_rst);
    exp_q.push_back(pack_exp(m));
    @(posedge clk);
    @(negedge clk);
    e = exp_q.pop_front();
    check(phase, {24'd0, pack_dut()}, {24'd0, e});
    if (kbd_rst_req) req_seen++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Asynchronous reset pulse, checked before the next clock edge.
  task automatic pulse_reset();
    res_n = 1'b0;
    m = model_reset();
    #1;
    check("async_rst", {24'd0, pack_dut()}, {24'd0, pack_exp(m)});
    #1;
    res_n = 1'b1;
  endtask

  // Runs the POR sequence and measures the first edge with RST_OE low.
  task automatic por_run(input string tag);
    int first_low;
    first_low = 0;
    phase = tag;
    for (int i = 1; i <= POR_C + 4; i++) begin
      step();
      if (!rst_oe && first_low == 0) first_low = i;
    end
    check({tag, "_release_edge"}, first_low, POR_C);
  endtask

  int t_first;
  int ext_cnt;
  int low_cnt;

  initial begin
    res_n   = 1'b0;
    kclk    = 1'b1;
    cpu_rst = 1'b0;
    m       = model_reset();
    @(negedge clk);
    check("reset_state", {24'd0, pack_dut()}, {24'd0, 8'b000_111_0_0});

    // Power-on, then a re-assert partway through the count.
    pulse_reset();
    por_run("por");
    steps(4);
    pulse_reset();
    phase = "por_partial";
    steps(8);
    pulse_reset();
    por_run("por_restart");
    steps(4);

    // Keyboard bit-length pulses never qualify.
    phase = "short_kclk";
    req_seen = 0;
    for (int r = 0; r < 8; r++) begin
      kclk = 1'b0;
      steps(10);
      kclk = 1'b1;
      steps(10);
    end
    check("short_kclk_req", req_seen, 0);
    check("short_kclk_state", {29'd0, state}, 32'd1);

`ifdef AMIGA_RESET_KBD_RESET_EN
    // Long KCLK low: assert after 2 sync edges + KBD_C counts.
    phase = "kbd_rst";
    req_seen = 0;
    t_first = 0;
    kclk = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      step();
      if (rst_oe && t_first == 0) t_first = i;
    end
    check("kbd_assert_edge", t_first, 2 + KBD_C);
    check("kbd_req_pulses", req_seen, 1);
    // Release: 2 sync edges, 1 edge into HOLD, then HOLD_C counts.
    kclk = 1'b1;
    t_first = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (!rst_oe && t_first == 0) t_first = i;
    end
    check("kbd_release_edge", t_first, 3 + HOLD_C);

    // HOLD restart: KCLK dips for 3 cycles at hold count 5.
    phase = "hold_restart";
    kclk = 1'b0;
    steps(40);
    kclk = 1'b1;
    steps(3 + 5);
    kclk = 1'b0;
    steps(3);
    kclk = 1'b1;
    t_first = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (!rst_oe && t_first == 0) t_first = i;
    end
    // Synced low persists 2 edges past the rise; count restarts there.
    check("hold_restart_release", t_first, 2 + HOLD_C);
    steps(4);
`else
    // KCLK ignored: a long low leaves the controller in RUN.
    phase = "kclk_ignored";
    req_seen = 0;
    low_cnt = 0;
    kclk = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (rst_oe) low_cnt++;
    end
    kclk = 1'b1;
    steps(4);
    check("kclk_ignored_oe", low_cnt, 0);
    check("kclk_ignored_req", req_seen, 0);
`endif

    // CPU RESET instruction: sensed with a 3-cycle lag, FSM untouched.
    phase = "cpu_reset";
    t_first = 0;
    ext_cnt = 0;
    low_cnt = 0;
    cpu_rst = 1'b1;
    for (int i = 1; i <= 124; i++) begin
      step();
      if (ext_rst) ext_cnt++;
      if (ext_rst && t_first == 0) t_first = i;
      if (rst_oe || hlt_oe) low_cnt++;
    end
    cpu_rst = 1'b0;
    for (int i = 125; i <= 140; i++) begin
      step();
      if (ext_rst) ext_cnt++;
      if (rst_oe || hlt_oe) low_cnt++;
    end
    check("ext_lag", t_first, 3);
    check("ext_width", ext_cnt, 124);
    check("ext_no_drive", low_cnt, 0);
    check("ext_state", {29'd0, state}, 32'd1);

    // Mid-operation reset then a full POR again.
    pulse_reset();
    por_run("por_final");
    steps(6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
